// File: rtl/dmux_stream.sv
// dmux_stream: registered N-way stream demultiplexer with valid/ready on the
// input and on every output channel. Each channel owns a one-entry register
// whose data reads as zero while the channel is empty.
// Optional feature macro: DMUX_STREAM_BCAST_EN (adds the `bcast` input that
// writes one word to every channel at once).
module dmux_stream #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SEL_BITS = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  in,
  input  logic [SEL_BITS-1:0]               sel,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [(2**SEL_BITS)*WIDTH-1:0]    out,
  output logic [(2**SEL_BITS)-1:0]          out_valid,
  input  logic [(2**SEL_BITS)-1:0]          out_ready
`ifdef DMUX_STREAM_BCAST_EN
  ,
  input  logic                              bcast
`endif
);

  localparam int unsigned N = 2**SEL_BITS;

  logic [N-1:0][WIDTH-1:0] slot_q, slot_d;
  logic [N-1:0]            valid_q, valid_d;
  logic [N-1:0]            free;
  logic [N-1:0]            sel_oh;
  logic [N-1:0]            wr;
  logic                    xfer;
  logic                    bcast_w;

`ifdef DMUX_STREAM_BCAST_EN
  assign bcast_w = bcast;
`else
  assign bcast_w = 1'b0;
`endif

  assign out       = slot_q;
  assign out_valid = valid_q;

  // Acceptance and per-channel next state; a write to a draining slot wins so
  // the channel stays full with the new word and no bubble appears.
  always_comb begin
    free     = ~valid_q | out_ready;
    sel_oh   = N'(1) << sel;
    in_ready = bcast_w ? (&free) : free[sel];
    xfer     = in_valid & in_ready;
    wr       = '0;
    if (xfer) begin
      wr = bcast_w ? '1 : sel_oh;
    end
    slot_d  = slot_q;
    valid_d = valid_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (wr[k]) begin
        slot_d[k]  = in;
        valid_d[k] = 1'b1;
      end else if (valid_q[k] && out_ready[k]) begin
        slot_d[k]  = '0;
        valid_d[k] = 1'b0;
      end
    end
  end

  // Channel registers; reset discards everything held or in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q  <= '0;
      valid_q <= '0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_dmux_stream.sv
// tb_dmux_stream: directed and randomized checks of dmux_stream against a
// per-channel mailbox model (one word per channel, zero when empty).
module tb_dmux_stream;

  localparam int W = 16;
  localparam int N = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [W-1:0]    din;
  logic [2:0]      sel;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  dout;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic            b;

  int checks = 0;
  int passes = 0;

  // Reference model: mailbox contents and occupancy per channel.
  logic [W-1:0] mbox [N];
  bit           full [N];

  always #5 clk = ~clk;

  dmux_stream #(.WIDTH(16), .SEL_BITS(3)) dut (
    .clk(clk),
    .reset(rst),
    .in(din),
    .sel(sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out(dout),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DMUX_STREAM_BCAST_EN
    ,
    .bcast(b)
`endif
  );

  function automatic bit model_ready();
    if (b) begin
      for (int k = 0; k < N; k++)
        if (full[k] && !out_ready[k]) return 1'b0;
      return 1'b1;
    end
    return !full[sel] || out_ready[sel];
  endfunction

  function automatic logic [N-1:0] model_valid();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = full[k];
    return v;
  endfunction

  function automatic logic [N*W-1:0] model_flat();
    logic [N*W-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = full[k] ? mbox[k] : '0;
    return f;
  endfunction

  task automatic chk_ready();
    logic e;
    e = model_ready();
    checks++;
    assert (in_ready === e) passes++;
    else $error("FAIL in_ready got=%0b exp=%0b sel=%0d", in_ready, e, sel);
  endtask

  task automatic chk_out();
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    ev = model_valid();
    ed = model_flat();
    checks++;
    assert (out_valid === ev) passes++;
    else $error("FAIL out_valid got=%b exp=%b", out_valid, ev);
    checks++;
    assert (dout === ed) passes++;
    else $error("FAIL out got=%h exp=%h", dout, ed);
  endtask

  // One clock: check combinational ready, advance the model at the edge,
  // then check the registered outputs just after it.
  task automatic cycle();
    bit acc;
    #1;
    if (!rst) chk_ready();
    @(posedge clk);
    acc = in_valid && model_ready();
    if (rst) begin
      for (int k = 0; k < N; k++) begin full[k] = 0; mbox[k] = '0; end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (acc && (b || k == int'(sel))) begin
          mbox[k] = din;
          full[k] = 1;
        end else if (full[k] && out_ready[k]) begin
          full[k] = 0;
          mbox[k] = '0;
        end
      end
    end
    #1;
    chk_out();
  endtask

  task automatic chk_const(input string tag, input logic [N*W-1:0] got,
                           input logic [N*W-1:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  initial begin
    rst = 1; din = '0; sel = '0; in_valid = 0; out_ready = '0; b = 0;
    for (int k = 0; k < N; k++) begin full[k] = 0; mbox[k] = '0; end
    cycle();
    rst = 0;
    // Ready for every select straight out of reset.
    for (int s = 0; s < N; s++) begin
      sel = 3'(s);
      #1;
      chk_const("ready_after_reset", {{(N*W-1){1'b0}}, in_ready}, 1);
    end

    // Unicast to channel 5.
    din = 16'hA5A5; sel = 3'd5; in_valid = 1;
    cycle();
    chk_const("unicast_valid", {{(N*W-N){1'b0}}, out_valid}, 8'b0010_0000);
    chk_const("unicast_data", dout, {16'h0, 16'h0, 16'hA5A5, {5{16'h0}}});

    // Back-pressure on 5, then a different channel still gets through.
    din = 16'h1234; sel = 3'd5;
    #1;
    chk_const("bp_ready", {{(N*W-1){1'b0}}, in_ready}, 0);
    cycle();
    chk_const("bp_hold", {{(N*W-W){1'b0}}, dout[5*W +: W]}, 16'hA5A5);
    sel = 3'd2;
    cycle();
    chk_const("ch2_data", {{(N*W-W){1'b0}}, dout[2*W +: W]}, 16'h1234);

    // Pass-through stream on channel 3 with its consumer always ready.
    out_ready = 8'b0000_1000; sel = 3'd3;
    for (int i = 1; i <= 16; i++) begin
      din = 16'(i);
      cycle();
      chk_const("stream_ch3", {{(N*W-W){1'b0}}, dout[3*W +: W]}, (N*W)'(i));
    end

    // Select sweep with every consumer draining.
    out_ready = '1;
    for (int s = 0; s < N; s++) begin
      for (int v = 0; v < 2; v++) begin
        sel = 3'(s); din = v ? 16'hFFFF : 16'h0000;
        cycle();
        chk_const("sweep_onehot", {{(N*W-N){1'b0}}, out_valid}, (N*W)'(1) << s);
      end
    end
    in_valid = 0;
    cycle();

    // Fill 1, 4, 7 then reset with a transfer pending.
    out_ready = '0; in_valid = 1;
    foreach (mbox[k]) if (k == 1 || k == 4 || k == 7) begin
      sel = 3'(k); din = 16'(16'h100 + k);
      cycle();
    end
    rst = 1; sel = 3'd1; din = 16'h7777;
    cycle();
    chk_const("reset_mid", {out_valid, dout}, '0);
    rst = 0;

`ifdef DMUX_STREAM_BCAST_EN
    // Broadcast blocked by a full, stalled channel 6, then released.
    b = 0; sel = 3'd6; din = 16'h0606; in_valid = 1; out_ready = '0;
    cycle();
    b = 1; din = 16'hBEEF;
    #1;
    chk_const("bcast_blocked", {{(N*W-1){1'b0}}, in_ready}, 0);
    cycle();
    out_ready = 8'b0100_0000;
    cycle();
    chk_const("bcast_all", dout, {N{16'hBEEF}});
    b = 0; out_ready = '1; in_valid = 0;
    cycle();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, N - 1));
      din       = 16'($urandom);
      out_ready = 8'($urandom);
`ifdef DMUX_STREAM_BCAST_EN
      b = ($urandom_range(0, 7) == 0);
`endif
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmux_stream.md
# dmux_stream

Registered, parametrised N-way demultiplexer with valid/ready flow control on the input and on every output channel. It routes each accepted WIDTH-bit input word to the channel chosen by `sel`, holding it in a one-entry per-channel output register until that channel's consumer takes it. It sits between a single producer (bus/ALU result path) and N independent consumers, and replaces fixed 8-way, 1-bit combinational demultiplexing wherever back-pressure or wider data is needed.

## Interface
- `WIDTH`, 16: data word width in bits (≥1).
- `SEL_BITS`, 3: select width; channel count N = 2**SEL_BITS (derived localparam, not overridable).
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset, sampled on rising edge of `clk`.
- `in`  input  WIDTH  data word from producer.
- `sel`  input  SEL_BITS  destination channel index for `in`.
- `in_valid`  input  1  producer offers `in`/`sel` this cycle.
- `in_ready`  output  1  block accepts the offered word this cycle (combinational).
- `out`  output  N*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- `out_valid`  output  N  bit k: channel k register holds a word.
- `out_ready`  input  N  bit k: consumer k takes the word this cycle.

## Operation
- Per channel k: one register `slot[k]` (WIDTH) plus full flag `out_valid[k]`.
- Input transfer: `in_valid & in_ready` at a rising edge.
- Output transfer on channel k: `out_valid[k] & out_ready[k]` at a rising edge.
- `in_ready = ~out_valid[sel] | out_ready[sel]` (slot empty, or draining this same cycle).
- On input transfer: `slot[sel] <= in`, `out_valid[sel] <= 1`.
- On output transfer on k with no simultaneous input transfer to k: `out_valid[k] <= 0`, `slot[k] <= 0`.
- Simultaneous output and input transfer on the same channel: new word replaces old, `out_valid[k]` stays 1; no bubble.
- Channels not addressed by `sel` are unaffected by input; all channels drain independently and concurrently.
- Channel data is 0 whenever `out_valid[k]` = 0. This matches the zero-on-unselected demux convention.
- `in_valid` low: `sel` and `in` are don't-care; no state change from the input side.
- Word order is preserved per channel. There is no ordering relation across channels.

## Timing
- Reset (`reset`=1 at an edge): all `out_valid` = 0, all `out` = 0. Reset overrides any same-cycle transfer, and words in flight are discarded. `in_ready` after reset = 1 for any `sel` (combinational from cleared state).
- Latency: a word accepted at edge t appears on `out[sel]` with `out_valid[sel]`=1 immediately after edge t (1-cycle registered).
- Throughput: 1 word/cycle to one channel, provided its consumer holds `out_ready`=1. Full back-pressure on one channel blocks only inputs addressed to that channel.
- `out`/`out_valid` are registered outputs and stable between edges. `out[k]` is held constant while `out_valid[k]`=1 and `out_ready[k]`=0.
- `in_ready` is combinational in `sel`, `out_valid`, `out_ready`. Producer must not make `in_valid` depend on `in_ready`.

## Configuration
- `DMUX_STREAM_BCAST_EN` defined: adds input port `bcast` (1 bit).
  - With `bcast`=1, `in_ready = &(~out_valid | out_ready)`.
  - On transfer, `in` is written to every slot and all `out_valid` are set; `sel` is ignored.
  - With `bcast`=0, behaviour is as above.
- Not defined: no `bcast` port, unicast only; logic identical to `bcast`=0.

## Test plan
- Reset then unicast: WIDTH=16, `reset`=1 one cycle, then `in`=16'hA5A5, `sel`=5, `in_valid`=1, all `out_ready`=0 → next cycle `out_valid`=8'b0010_0000, channel 5 = A5A5, other channels 0.
- Back-pressure: channel 5 still full, offer `in`=16'h1234 `sel`=5 with `out_ready[5]`=0 → `in_ready`=0, channel 5 holds A5A5. Same cycle `sel`=2 → `in_ready`=1, channel 2 = 1234 next cycle.
- Pass-through: `out_ready[3]`=1 held, stream 0x0001..0x0010 to `sel`=3 every cycle → `in_ready` constantly 1; channel 3 shows each value one cycle after acceptance, no gaps.
- Exhaustive select sweep: for `sel`=0..7 and `in`∈{0, FFFF}, single transfers with the consumer draining → exactly one `out_valid` bit set per transfer. This covers all 16 legacy demux cases scaled to WIDTH.
- Reset mid-operation: channels 1, 4, 7 full, assert `reset` with `in_valid`=1 `sel`=1 → after the edge, all `out_valid`=0 and all `out`=0.
- `DMUX_STREAM_BCAST_EN`:
  - `bcast`=1, `in`=16'hBEEF, channel 6 full and not ready → `in_ready`=0.
  - Release `out_ready[6]` → all 8 channels = BEEF next cycle.
